// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: small circular FIFO between Simple_ALU and the writeback
// port. It holds result packets (plus their toggle bit) while writeback is
// busy, back-pressures the issue stage when full, and empties on a flush.

package alu_wb_pkg;

   // Completion/status flags carried with each result.
   typedef struct packed {
      logic executed;
      logic destValid;
   } wbFlags;

   // Result packet produced by Simple_ALU.
   typedef struct packed {
      logic        valid;
      logic [7:0]  seqNo;
      logic [4:0]  destReg;
      logic [31:0] destData;
      wbFlags      flags;
      logic [3:0]  exception;
   } wbPkt;

endpackage : alu_wb_pkg

module alu_wb_buffer
   import alu_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  wbPkt                       wbPacket_i,
   input  logic                       toggleFlag_i,
   input  logic                       recoverFlag_i,
   input  logic                       wbReady_i,
   output wbPkt                       wbPacket_o,
   output logic                       toggleFlag_o,
   output logic                       stall_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // One stored slot: the packet exactly as received plus its toggle bit.
   typedef struct packed {
      logic toggle;
      wbPkt pkt;
   } entry_t;

   // Storage is not reset; outputs are gated by the occupancy count instead.
   entry_t          mem_q [DEPTH];

   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;

   logic            full;
   logic            empty;
   logic            enq;
   logic            deq;

   // Status decode and handshake qualification from registered state only.
   always_comb begin
      full  = (count_q == CW'(DEPTH));
      empty = (count_q == '0);
      // A flush wins over both sides; a full buffer refuses input even if
      // the head leaves this same cycle (upstream holds while stalled).
      enq   = wbPacket_i.valid && !full && !recoverFlag_i;
      deq   = !empty && wbReady_i && !recoverFlag_i;
   end

   // Next-state for pointers and occupancy, with explicit wrap at DEPTH-1.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (recoverFlag_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) begin
            tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
         end
         if (deq) begin
            head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
         end
         unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers; reset clears them without waiting for clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry write at the tail; every field is stored unmodified.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_q[tail_q] <= '{toggle: toggleFlag_i, pkt: wbPacket_i};
      end
   end

   // Head presentation: valid forced high when occupied, all-zero when empty.
   always_comb begin
      wbPacket_o   = '0;
      toggleFlag_o = 1'b0;
      if (!empty) begin
         wbPacket_o       = mem_q[head_q].pkt;
         wbPacket_o.valid = 1'b1;
         toggleFlag_o     = mem_q[head_q].toggle;
      end
   end

   // Back-pressure and occupancy are straight decodes of the count register.
   always_comb begin
      stall_o = full;
      count_o = count_q;
   end

endmodule : alu_wb_buffer

// File: tb/tb_alu_wb_buffer.sv
// Directed testbench for alu_wb_buffer (DEPTH=2).

module tb_alu_wb_buffer;
   import alu_wb_pkg::*;

   localparam int DEPTH = 2;

   logic       clk;
   logic       reset;
   wbPkt       wbPacket_i;
   logic       toggleFlag_i;
   logic       recoverFlag_i;
   logic       wbReady_i;
   wbPkt       wbPacket_o;
   logic       toggleFlag_o;
   logic       stall_o;
   logic [1:0] count_o;

   int checks;
   int failures;

   alu_wb_buffer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .wbPacket_i    (wbPacket_i),
      .toggleFlag_i  (toggleFlag_i),
      .recoverFlag_i (recoverFlag_i),
      .wbReady_i     (wbReady_i),
      .wbPacket_o    (wbPacket_o),
      .toggleFlag_o  (toggleFlag_o),
      .stall_o       (stall_o),
      .count_o       (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic wbPkt mk(input logic [7:0] seq, input logic [31:0] data);
      wbPkt p;
      p                 = '0;
      p.valid           = 1'b1;
      p.seqNo           = seq;
      p.destReg         = seq[4:0];
      p.destData        = data;
      p.flags.executed  = seq[0];
      p.flags.destValid = seq[1];
      p.exception       = seq[5:2];
      return p;
   endfunction

   // Advance one clock edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wbPacket_i    = '0;
      toggleFlag_i  = 1'b0;
      recoverFlag_i = 1'b0;
      wbReady_i     = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      #1;
      checks++;
      if (count_o !== 2'd0 || stall_o !== 1'b0 || wbPacket_o !== '0 || toggleFlag_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: count=%0d stall=%b pkt=%h tog=%b, required 0/0/0/0",
                  count_o, stall_o, wbPacket_o, toggleFlag_o);
      end
      tick();
      reset = 1'b0;
      tick();
      $display("reset done: count=%0d", count_o);
   endtask

   task automatic test_single_pass();
      wbReady_i  = 1'b1;
      wbPacket_i = mk(8'd5, 32'h1234);
      tick();
      wbPacket_i = '0;
      checks++;
      if (count_o !== 2'd1 || wbPacket_o !== mk(8'd5, 32'h1234)) begin
         failures++;
         $display("FAIL single_pass_out: count=%0d pkt=%h, required count=1 pkt=%h",
                  count_o, wbPacket_o, mk(8'd5, 32'h1234));
      end
      $display("single pass: out seq=%0d data=%h", wbPacket_o.seqNo, wbPacket_o.destData);
      tick();
      checks++;
      if (count_o !== 2'd0 || wbPacket_o !== '0) begin
         failures++;
         $display("FAIL single_pass_drain: count=%0d pkt=%h, required 0/0", count_o, wbPacket_o);
      end
      idle_inputs();
   endtask

   task automatic test_fill();
      wbReady_i  = 1'b0;
      wbPacket_i = mk(8'd1, 32'h11);
      tick();
      wbPacket_i = mk(8'd2, 32'h22);
      tick();
      wbPacket_i = mk(8'd3, 32'h33);
      checks++;
      if (count_o !== 2'd2 || stall_o !== 1'b1) begin
         failures++;
         $display("FAIL fill_full: count=%0d stall=%b, required 2/1", count_o, stall_o);
      end
      tick();
      checks++;
      if (count_o !== 2'd2 || wbPacket_o.seqNo !== 8'd1) begin
         failures++;
         $display("FAIL fill_hold: count=%0d head=%0d, required 2/1", count_o, wbPacket_o.seqNo);
      end
      // Full: dequeue of 1 happens but packet 3 must not be taken this edge.
      wbReady_i = 1'b1;
      tick();
      checks++;
      if (count_o !== 2'd1 || wbPacket_o.seqNo !== 8'd2 || stall_o !== 1'b0) begin
         failures++;
         $display("FAIL fill_no_enq_when_full: count=%0d head=%0d stall=%b, required 1/2/0",
                  count_o, wbPacket_o.seqNo, stall_o);
      end
      $display("fill: popped 1, head now %0d", wbPacket_o.seqNo);
      tick();
      wbPacket_i = '0;
      checks++;
      if (count_o !== 2'd1 || wbPacket_o !== mk(8'd3, 32'h33)) begin
         failures++;
         $display("FAIL fill_accept3: count=%0d pkt=%h, required 1/%h",
                  count_o, wbPacket_o, mk(8'd3, 32'h33));
      end
      tick();
      checks++;
      if (count_o !== 2'd0) begin
         failures++;
         $display("FAIL fill_drain: count=%0d, required 0", count_o);
      end
      idle_inputs();
   endtask

   task automatic test_wrap();
      int next_in;
      int next_out;
      bit accept;
      next_in  = 0;
      next_out = 0;
      for (int cyc = 0; cyc < 40 && next_out < 6; cyc++) begin
         wbPacket_i = (next_in < 6) ? mk(8'(next_in), 32'(32'hA000 + next_in)) : '0;
         wbReady_i  = (cyc % 2 == 0);
         #0;
         accept = wbPacket_i.valid && !stall_o;
         if (count_o != 0 && wbReady_i) begin
            checks++;
            if (wbPacket_o !== mk(8'(next_out), 32'(32'hA000 + next_out))) begin
               failures++;
               $display("FAIL wrap_order: got seq=%0d data=%h, required seq=%0d data=%h",
                        wbPacket_o.seqNo, wbPacket_o.destData, next_out, 32'hA000 + next_out);
            end else begin
               $display("wrap: popped seq=%0d", wbPacket_o.seqNo);
            end
            next_out++;
         end
         tick();
         if (accept) next_in++;
      end
      checks++;
      if (next_out != 6 || count_o !== 2'd0) begin
         failures++;
         $display("FAIL wrap_complete: popped=%0d count=%0d, required 6/0", next_out, count_o);
      end
      idle_inputs();
   endtask

   task automatic test_flush();
      wbReady_i  = 1'b0;
      wbPacket_i = mk(8'd1, 32'h1);
      tick();
      wbPacket_i = mk(8'd2, 32'h2);
      tick();
      wbPacket_i    = mk(8'd7, 32'h7);
      recoverFlag_i = 1'b1;
      tick();
      checks++;
      if (count_o !== 2'd0 || wbPacket_o !== '0 || stall_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_clear: count=%0d pkt=%h stall=%b, required 0/0/0",
                  count_o, wbPacket_o, stall_o);
      end
      recoverFlag_i = 1'b0;
      wbPacket_i    = '0;
      tick();
      checks++;
      if (count_o !== 2'd0) begin
         failures++;
         $display("FAIL flush_discard: count=%0d, required 0", count_o);
      end
      wbPacket_i = mk(8'd8, 32'h88);
      tick();
      wbPacket_i = '0;
      checks++;
      if (count_o !== 2'd1 || wbPacket_o.seqNo !== 8'd8) begin
         failures++;
         $display("FAIL flush_restart: count=%0d head=%0d, required 1/8", count_o, wbPacket_o.seqNo);
      end
      $display("flush: restart head seq=%0d", wbPacket_o.seqNo);
      wbReady_i = 1'b1;
      tick();
      idle_inputs();
   endtask

   task automatic test_toggle();
      wbReady_i    = 1'b0;
      wbPacket_i   = mk(8'd8, 32'h8);
      toggleFlag_i = 1'b0;
      tick();
      wbPacket_i   = mk(8'd9, 32'h9);
      toggleFlag_i = 1'b1;
      tick();
      wbPacket_i   = '0;
      toggleFlag_i = 1'b0;
      checks++;
      if (wbPacket_o.seqNo !== 8'd8 || toggleFlag_o !== 1'b0) begin
         failures++;
         $display("FAIL toggle_first: seq=%0d tog=%b, required 8/0", wbPacket_o.seqNo, toggleFlag_o);
      end
      wbReady_i = 1'b1;
      tick();
      checks++;
      if (wbPacket_o.seqNo !== 8'd9 || toggleFlag_o !== 1'b1) begin
         failures++;
         $display("FAIL toggle_second: seq=%0d tog=%b, required 9/1", wbPacket_o.seqNo, toggleFlag_o);
      end
      tick();
      checks++;
      if (count_o !== 2'd0 || toggleFlag_o !== 1'b0) begin
         failures++;
         $display("FAIL toggle_empty: count=%0d tog=%b, required 0/0", count_o, toggleFlag_o);
      end
      $display("toggle: sequence done");
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      wbReady_i  = 1'b0;
      wbPacket_i = mk(8'd20, 32'h20);
      tick();
      wbReady_i  = 1'b1;
      wbPacket_i = mk(8'd21, 32'h21);
      tick();
      checks++;
      if (count_o !== 2'd1 || wbPacket_o.seqNo !== 8'd21) begin
         failures++;
         $display("FAIL b2b_first: count=%0d head=%0d, required 1/21", count_o, wbPacket_o.seqNo);
      end
      wbPacket_i = mk(8'd22, 32'h22);
      tick();
      checks++;
      if (count_o !== 2'd1 || wbPacket_o !== mk(8'd22, 32'h22)) begin
         failures++;
         $display("FAIL b2b_second: count=%0d pkt=%h, required 1/%h", count_o, wbPacket_o, mk(8'd22, 32'h22));
      end
      $display("back_to_back: head seq=%0d", wbPacket_o.seqNo);
      wbPacket_i = '0;
      tick();
      checks++;
      if (count_o !== 2'd0) begin
         failures++;
         $display("FAIL b2b_drain: count=%0d, required 0", count_o);
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      wbReady_i  = 1'b0;
      wbPacket_i = mk(8'd30, 32'h30);
      toggleFlag_i = 1'b1;
      tick();
      wbPacket_i   = '0;
      toggleFlag_i = 1'b0;
      checks++;
      if (count_o !== 2'd1 || toggleFlag_o !== 1'b1) begin
         failures++;
         $display("FAIL async_pre: count=%0d tog=%b, required 1/1", count_o, toggleFlag_o);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (count_o !== 2'd0 || wbPacket_o !== '0 || toggleFlag_o !== 1'b0 || stall_o !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: count=%0d pkt=%h tog=%b stall=%b, required all 0",
                  count_o, wbPacket_o, toggleFlag_o, stall_o);
      end
      #1;
      reset = 1'b0;
      wbPacket_i = mk(8'd4, 32'h44);
      tick();
      wbPacket_i = '0;
      checks++;
      if (count_o !== 2'd1 || wbPacket_o !== mk(8'd4, 32'h44)) begin
         failures++;
         $display("FAIL async_restart: count=%0d pkt=%h, required 1/%h", count_o, wbPacket_o, mk(8'd4, 32'h44));
      end
      $display("async reset: restart head seq=%0d", wbPacket_o.seqNo);
      wbReady_i = 1'b1;
      tick();
      idle_inputs();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_single_pass();
      test_fill();
      test_wrap();
      test_flush();
      test_toggle();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alu_wb_buffer

// File: doc/alu_wb_buffer.md
ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of wbPkt entries held; legal values are 2 and 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wbPacket_i  input  wbPkt  result packet from Simple_ALU; wbPacket_i.valid qualifies it.
REQ-005 SHALL have port toggleFlag_i  input  1  toggle flag from Simple_ALU, paired with wbPacket_i.
REQ-006 SHALL have port recoverFlag_i  input  1  pipeline recovery/flush request.
REQ-007 SHALL have port wbReady_i  input  1  writeback port accepts head entry this cycle.
REQ-008 SHALL have port wbPacket_o  output  wbPkt  head entry to writeback/bypass network.
REQ-009 SHALL have port toggleFlag_o  output  1  toggle flag of head entry.
REQ-010 SHALL have port stall_o  output  1  back-pressure to the issue/register-read stage feeding Simple_ALU.
REQ-011 SHALL have port count_o  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-012 SHALL be a circular FIFO of DEPTH entries, each holding one wbPkt plus one toggle bit, with head pointer, tail pointer and occupancy counter.
REQ-013 Pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-014 Enqueue SHALL occur on a clock edge when wbPacket_i.valid=1, stall_o=0 and recoverFlag_i=0; the entry is written at tail, and the tail advances.
REQ-015 Packets with valid=1 are enqueued regardless of flags.executed, flags.destValid or exception bits; no field is modified.
REQ-016 wbPacket_o SHALL equal the head entry with valid forced to 1 when count_o>0, and SHALL be all-zero when count_o=0.
REQ-017 toggleFlag_o SHALL equal the head entry's toggle bit when count_o>0, else 0.
REQ-018 Dequeue SHALL occur on a clock edge when count_o>0, wbReady_i=1 and recoverFlag_i=0; the head advances.
REQ-019 Latency SHALL be one cycle: a packet enqueued at edge N appears on wbPacket_o after edge N when the FIFO was empty.
REQ-020 There SHALL be no combinational path from wbPacket_i to wbPacket_o.
REQ-021 stall_o SHALL be 1 exactly when count_o=DEPTH, as a combinational decode of the registered count.
REQ-022 When full, an incoming valid packet SHALL NOT be enqueued even if a dequeue occurs in the same cycle; upstream holds the packet while stall_o=1.
REQ-023 On simultaneous enqueue and dequeue with 0<count<DEPTH, count_o SHALL be unchanged and both pointers SHALL advance.
REQ-024 On simultaneous enqueue and dequeue with count=0: dequeue is suppressed (nothing valid), the enqueue occurs, and count_o becomes 1.
REQ-025 recoverFlag_i=1 SHALL, at the next edge, set count, head and tail to 0 and discard the incoming packet; it overrides enqueue and dequeue.
REQ-026 Entry storage is not required to be cleared on flush; outputs SHALL be zero whenever count_o=0.
REQ-027 count_o SHALL never exceed DEPTH and never underflow below 0.

Reset
REQ-028 On reset assertion, asynchronously and independent of clk: count, head and tail SHALL be 0; wbPacket_o=0; toggleFlag_o=0; stall_o=0; count_o=0.
REQ-029 Reset asserted mid-operation SHALL discard all held entries; the first enqueue after deassertion behaves as into an empty FIFO.

Verification
REQ-030 Single pass: seqNo=5, destData=0x1234, wbReady_i=1 -> seqNo 5, destData 0x1234 on wbPacket_o one cycle later; count_o returns 0 the cycle after.
REQ-031 Fill (DEPTH=2): wbReady_i=0, three valid packets seqNo 1,2,3 held by upstream -> count_o=2, stall_o=1, packet 3 not enqueued; wbReady_i=1 -> outputs 1 then 2, then packet 3 is accepted.
REQ-032 Wrap: 6 packets with wbReady_i toggled 1,0,1,0,... -> output order is seqNo 0..5 with none lost or duplicated; the pointers wrap.
REQ-033 Flush: count_o=2 with valid input, recoverFlag_i=1 -> next cycle count_o=0, wbPacket_o=0, and the input is discarded.
REQ-034 Toggle pass-through: toggleFlag_i=1 with seqNo 9 behind seqNo 8 (toggle 0) -> toggleFlag_o is 0 then 1, aligned with seqNo 8 then 9.
REQ-035 Async reset: reset pulse between edges with count_o=1 -> all outputs are 0 immediately, before the next clk edge.
